// File: rtl/data_mem_sweep.sv
// data_mem_sweep: single-port data RAM with a sequential clear sweep.
// Read latency: 0 cycles (combinational), or 1 cycle with DATA_MEM_REG_READ_EN.
// Backpressure: Busy is high during a sweep; writes then are dropped and flagged on WrErr.
//
// Optional feature macro: DATA_MEM_REG_READ_EN
//   defined   -> DataOut is registered (1-cycle latency, write-first bypass)
//   undefined -> DataOut is a combinational read of the array
//
// Ports:
//   Clk          system clock, all state changes on the rising edge
//   Reset        synchronous active-high reset; starts a full clear sweep
//   WriteEn      write strobe for the current cycle
//   ClearReq     single-cycle request to re-zero the whole array
//   DataAddress  read/write word address
//   DataIn       write data
//   DataOut      read data (0 while Busy or when the address is out of range)
//   Busy         high while a clear sweep is in progress
//   WrErr        one-cycle pulse per dropped write
//   WrCount      saturating count of accepted writes
module data_mem_sweep #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 1 << AW,
  parameter int CW    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic          ClearReq,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          Busy,
  output logic          WrErr,
  output logic [CW-1:0] WrCount
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          busy_n;

  logic [DW-1:0] core [DEPTH];

  logic addr_ok;
  logic wr_ok;
  logic wr_drop;

  assign addr_ok = ({1'b0, DataAddress} < DEPTH_W);

  // A write is taken only in READY, in range, and when no clear arrives in
  // the same cycle (the clear has priority).
  assign wr_ok   = (state == READY) && WriteEn && !ClearReq && addr_ok;
  assign wr_drop = WriteEn && !wr_ok;

  // Next-state logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    busy_n  = Busy;
    case (state)
      CLEAR: begin
        // ClearReq is deliberately ignored here: the sweep never restarts.
        ptr_n = ptr + AW'(1);
        if (ptr == LAST) begin
          state_n = READY;
          busy_n  = 1'b0;
          ptr_n   = '0;
        end
      end
      READY: begin
        if (ClearReq) begin
          state_n = CLEAR;
          ptr_n   = '0;
          busy_n  = 1'b1;
        end
      end
      default: begin
        state_n = CLEAR;
        ptr_n   = '0;
        busy_n  = 1'b1;
      end
    endcase
  end

  // State, status and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLEAR;
      ptr     <= '0;
      Busy    <= 1'b1;
      WrErr   <= 1'b0;
      WrCount <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      Busy  <= busy_n;
      WrErr <= wr_drop;
      if (wr_ok && (WrCount != CNT_MAX)) begin
        WrCount <= WrCount + CW'(1);
      end
    end
  end

  // Array: no reset, so a held Reset leaves contents untouched; the sweep
  // that follows Reset is what zeroes it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == CLEAR) begin
        core[ptr] <= '0;
      end else if (wr_ok) begin
        core[DataAddress] <= DataIn;
      end
    end
  end

`ifdef DATA_MEM_REG_READ_EN
  // Registered read with write-first bypass.
  always_ff @(posedge Clk) begin
    if (Reset || Busy) begin
      DataOut <= '0;
    end else if (wr_ok) begin
      DataOut <= DataIn;
    end else if (addr_ok) begin
      DataOut <= core[DataAddress];
    end else begin
      DataOut <= '0;
    end
  end
`else
  // Combinational read; a same-cycle write is not visible until the edge.
  always_comb begin
    DataOut = '0;
    if (!Busy && addr_ok) begin
      DataOut = core[DataAddress];
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_sweep.sv
// tb_data_mem_sweep: self-checking bench for data_mem_sweep.
// Drives inputs on the falling edge and samples outputs there as well.
// Works with and without DATA_MEM_REG_READ_EN (reads wait one edge).
module tb_data_mem_sweep;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          WriteEn;
  logic          ClearReq;
  logic [AW-1:0] DataAddress;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          Busy;
  logic          WrErr;
  logic [CW-1:0] WrCount;

  data_mem_sweep #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .WriteEn    (WriteEn),
    .ClearReq   (ClearReq),
    .DataAddress(DataAddress),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .Busy       (Busy),
    .WrErr      (WrErr),
    .WrCount    (WrCount)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DEPTH];
  int            mcount;
  logic [DW-1:0] sb_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Read through the scoreboard: expectation queued at drive time,
  // popped when the output is sampled one edge later.
  task automatic rd(input logic [AW-1:0] a);
    logic [DW-1:0] e;
    DataAddress = a;
    sb_q.push_back(model[a]);
    tick();
    e = sb_q.pop_front();
    chk($sformatf("read[%0h]", a), 32'(DataOut), 32'(e));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WriteEn     = 1'b1;
    DataAddress = a;
    DataIn      = d;
    tick();
    WriteEn  = 1'b0;
    model[a] = d;
    mcount   = (mcount < CMAX) ? mcount + 1 : CMAX;
    chk($sformatf("wrerr_after_wr[%0h]", a), 32'(WrErr), 0);
  endtask

  // Counts Busy samples until the sweep finishes, starting from 'start'
  // samples already seen. Bounded so a stuck Busy cannot hang the run.
  task automatic wait_ready(input int start, output int cnt);
    int guard;
    cnt   = start;
    guard = 0;
    while (Busy && guard < 2000) begin
      tick();
      if (Busy) cnt++;
      guard++;
    end
    chk("sweep_ends", 32'(Busy), 0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{addr: 8'h10, din: 8'hA5};
    vecs[1] = '{addr: 8'hFF, din: 8'h3C};
    vecs[2] = '{addr: 8'h00, din: 8'h11};
    vecs[3] = '{addr: 8'h80, din: 8'hC3};
    model_clear();
    mcount = 0;

    Reset       = 1'b1;
    WriteEn     = 1'b0;
    ClearReq    = 1'b0;
    DataAddress = '0;
    DataIn      = '0;

    // 1: reset, then a full sweep of exactly DEPTH cycles
    repeat (3) tick();
    chk("rst_busy", 32'(Busy), 1);
    chk("rst_wrerr", 32'(WrErr), 0);
    chk("rst_wrcount", 32'(WrCount), 0);
    Reset = 1'b0;
    wait_ready(1, cnt);
    chk("busy_cycles_reset", cnt, DEPTH);
    rd(8'h00);
    rd(8'h7F);
    rd(8'hFF);

    // 2: table-driven writes, then read back
    for (int i = 0; i < 4; i++) begin
      wr(vecs[i].addr, vecs[i].din);
      chk($sformatf("wrcount_vec%0d", i), 32'(WrCount), mcount);
    end
    for (int i = 0; i < 4; i++) rd(vecs[i].addr);

    // read-during-write: old data before the edge, new data after
    DataAddress = 8'h10;
    DataIn      = 8'h99;
    WriteEn     = 1'b1;
`ifndef DATA_MEM_REG_READ_EN
    #1;
    chk("rdw_old", 32'(DataOut), 32'(model[8'h10]));
`endif
    tick();
    WriteEn      = 1'b0;
    model[8'h10] = 8'h99;
    mcount       = (mcount < CMAX) ? mcount + 1 : CMAX;
    chk("rdw_new", 32'(DataOut), 32'h99);

    // 3: runtime clear, dropped writes while Busy, ignored second ClearReq
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    cnt = 1;
    chk("clr_busy", 32'(Busy), 1);
    WriteEn     = 1'b1;
    DataAddress = 8'h10;
    DataIn      = 8'hEE;
    tick();
    cnt++;
    chk("drop_wrerr", 32'(WrErr), 1);
    chk("drop_wrcount", 32'(WrCount), mcount);
    chk("busy_forces_zero", 32'(DataOut), 0);
    tick();
    cnt++;
    chk("drop_wrerr_b2b", 32'(WrErr), 1);
    WriteEn  = 1'b0;
    ClearReq = 1'b1;
    tick();
    cnt++;
    ClearReq = 1'b0;
    chk("drop_wrerr_fall", 32'(WrErr), 0);
    wait_ready(cnt, cnt);
    chk("busy_cycles_clr", cnt, DEPTH);
    chk("clr_keeps_wrcount", 32'(WrCount), mcount);
    model_clear();
    rd(8'h10);
    rd(8'h80);

    // 4: ClearReq and WriteEn together -> clear wins
    wr(8'h05, 8'h31);
    ClearReq    = 1'b1;
    WriteEn     = 1'b1;
    DataAddress = 8'h05;
    DataIn      = 8'h77;
    tick();
    ClearReq = 1'b0;
    WriteEn  = 1'b0;
    chk("both_wrerr", 32'(WrErr), 1);
    chk("both_busy", 32'(Busy), 1);
    chk("both_wrcount", 32'(WrCount), mcount);
    wait_ready(1, cnt);
    chk("busy_cycles_both", cnt, DEPTH);
    model_clear();
    rd(8'h05);

    // write counter saturation
    for (int i = 0; i < 20; i++) wr(AW'(i), DW'(i * 3 + 1));
    chk("wrcount_sat", 32'(WrCount), CMAX);
    rd(8'h03);
    rd(8'h13);

    // 5: Reset in the middle of a sweep restarts it from zero
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    repeat (99) tick();
    Reset = 1'b1;
    repeat (2) tick();
    chk("midrst_busy", 32'(Busy), 1);
    chk("midrst_wrcount", 32'(WrCount), 0);
    Reset = 1'b0;
    wait_ready(1, cnt);
    chk("busy_cycles_midrst", cnt, DEPTH);
    chk("midrst_wrcount_after", 32'(WrCount), 0);
    mcount = 0;
    model_clear();
    rd(8'h03);

`ifdef DATA_MEM_REG_READ_EN
    // 6: registered read bypass and one-cycle latency on address change
    WriteEn     = 1'b1;
    DataAddress = 8'h08;
    DataIn      = 8'h5A;
    tick();
    WriteEn     = 1'b0;
    model[8'h08] = 8'h5A;
    chk("reg_bypass", 32'(DataOut), 32'h5A);
    DataAddress = 8'h09;
    #1;
    chk("reg_hold", 32'(DataOut), 32'h5A);
    tick();
    chk("reg_addr_change", 32'(DataOut), 32'(model[8'h09]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_sweep.md
Name: data_mem_sweep

Overview:
Parametrised single-port data memory for the lab datapath. It is the next-generation data RAM, generalised in data width and depth. Reset clears the array with a sequential one-word-per-cycle sweep instead of a single-cycle all-word reset, and the same sweep can be requested at runtime. Adds a busy/ready handshake, a dropped-write error flag and a saturating write counter. Sits between the ALU/address path and the register-file writeback mux.

Parameters:
DW, 8, data word width in bits
AW, 8, address width in bits
DEPTH, 1<<AW, number of words; must be ≤ 2**AW
CW, 16, write-counter width

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
WriteEn  in  1  write strobe for the current cycle
ClearReq  in  1  single-cycle request to re-zero the whole array
DataAddress  in  AW  read/write word address
DataIn  in  DW  write data
DataOut  out  DW  read data
Busy  out  1  high while a clear sweep is in progress; registered
WrErr  out  1  one-cycle pulse: a write was dropped; registered
WrCount  out  CW  number of accepted writes, saturating; registered

Behaviour:
- State machine: CLEAR, READY. Internal sweep pointer ptr (AW bits).
- Reset high at a clock edge:
  - state <= CLEAR, ptr <= 0, Busy <= 1, WrErr <= 0, WrCount <= 0.
  - No array writes occur while Reset is held.
- CLEAR, Reset low:
  - Each cycle writes Core[ptr] <= 0 and increments ptr.
  - On the edge that writes word DEPTH-1: state <= READY, Busy <= 0.
  - Busy is therefore high for exactly DEPTH cycles after Reset falls.
- Reset asserted mid-sweep: the sweep restarts from ptr=0 when Reset falls. Words already zeroed stay zero.
- READY:
  - WriteEn=1 writes Core[DataAddress] <= DataIn at the edge. WrCount increments, saturating at 2**CW-1.
  - ClearReq=1 gives state <= CLEAR, ptr <= 0, Busy <= 1 on that edge.
- Simultaneous ClearReq and WriteEn in READY: the clear wins, the write is dropped, WrErr=1 for the following cycle, WrCount unchanged.
- WriteEn=1 while in CLEAR (Busy=1): the write is dropped and WrErr pulses for one cycle. Each dropped cycle produces its own pulse, so back-to-back drops hold WrErr high.
- ClearReq while already in CLEAR: ignored; the sweep does not restart.
- Reads are combinational: DataOut = Core[DataAddress].
  - A write at an edge is visible on DataOut from that edge onward.
  - Same-cycle read-during-write returns the old data.
- While Busy=1, DataOut is forced to 0 regardless of address.
- DataAddress ≥ DEPTH, only possible when DEPTH < 2**AW:
  - Writes are dropped with WrErr pulsed.
  - Reads return 0.
- WrErr and WrCount are reset to 0 by Reset only; ClearReq does not reset them.

Optional Feature:
Macro DATA_MEM_REG_READ_EN.
- Defined:
  - DataOut is a register updated every edge, giving 1-cycle read latency.
  - Write-first bypass: if WriteEn is accepted at DataAddress, DataOut <= DataIn at that edge.
  - DataOut resets to 0 and is loaded with 0 while Busy.
- Not defined: combinational read exactly as described in Behaviour.

Test Plan:
1. Reset 3 cycles then low, with DEPTH=256 → Busy=1 for exactly 256 cycles. Then reading addresses 0, 0x7F, 0xFF gives DataOut=0x00.
2. READY: write 0xA5 to 0x10 and 0x3C to 0xFF, then read back → 0xA5 and 0x3C. WrCount=2, WrErr stays 0.
3. Pulse ClearReq in READY, then WriteEn to 0x20 while Busy → WrErr pulses 1 cycle, WrCount unchanged. After 256 cycles, 0x10 reads 0x00.
4. ClearReq and WriteEn(0x05, 0x77) in the same READY cycle → write dropped, WrErr=1 next cycle, Busy=1, address 0x05 reads 0x00 after the sweep.
5. Assert Reset at sweep cycle 100 for 2 cycles → Busy stays high until 256 cycles after Reset falls. WrCount=0.
6. With DATA_MEM_REG_READ_EN defined: write 0x5A to 0x08 with DataAddress=0x08 → DataOut=0x5A one cycle later (bypass). Changing to 0x09 shows 0x00 one cycle after the address change.
